alu_ctrl_mdu: RTL

Parametrised successor to the ALU controller in the single-cycle MIPS datapath. It keeps the same combinational ALUOp/funct decode and adds an iterative multiply/divide unit for mult, multu, div and divu, with HI/LO registers and mfhi/mflo result selection. While a multiply/divide runs, a stall output freezes the PC and pipeline registers. The block sits between the main decoder (ALUOp_i) and the ALU/write-back mux.

---
 rtl/alu_ctrl_mdu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_mdu.sv
// ALU control decode for the MIPS datapath plus an iterative multiply/divide unit
// with HI/LO registers; stall_o holds the pipeline while an MDU op is in flight.
module alu_ctrl_mdu #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [5:0]        funct_i,
    input  logic [2:0]        ALUOp_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic [3:0]        ALUCtrl_o,
    output logic              ALUSrc2_o,
    output logic [1:0]        mdu_sel_o,
    output logic              stall_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]   wk_q, wk_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                neg_q, neg_d;
    logic                rem_neg_q, rem_neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic                mdu_req;
    logic                s1, s2;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_acc_n, mul_wk_n;
    logic [DATA_W:0]     div_sh;
    logic                div_ge;
    logic [DATA_W-1:0]   div_acc_n, div_wk_n;
    logic [2*DATA_W-1:0] prod_u, prod_s;
    logic [DATA_W-1:0]   quo_s, rem_s;

    always_comb begin
        ALUCtrl_o = 4'd15;
        ALUSrc2_o = 1'b0;
        mdu_sel_o = 2'b00;
        case (ALUOp_i)
            3'b001: ALUCtrl_o = 4'd6;
            3'b010: ALUCtrl_o = 4'd2;
            3'b011: ALUCtrl_o = 4'd7;
            3'b100: ALUCtrl_o = 4'd10;
            3'b101: ALUCtrl_o = 4'd1;
            3'b110: ALUCtrl_o = 4'd11;
            3'b111: ALUCtrl_o = 4'd15;
            default: begin
                case (funct_i)
                    6'b100001: ALUCtrl_o = 4'd2;
                    6'b100011: ALUCtrl_o = 4'd6;
                    6'b100100: ALUCtrl_o = 4'd0;
                    6'b100101: ALUCtrl_o = 4'd1;
                    6'b101010: ALUCtrl_o = 4'd7;
                    6'b000011: begin
                        ALUCtrl_o = 4'd9;
                        ALUSrc2_o = 1'b1;
                    end
                    6'b000111: ALUCtrl_o = 4'd9;
                    6'b010000: mdu_sel_o = 2'b01;
                    6'b010010: mdu_sel_o = 2'b10;
                    default:   ALUCtrl_o = 4'd15;
                endcase
            end
        endcase
    end

    assign mdu_req = valid_i && (ALUOp_i == 3'b000) && (funct_i[5:2] == 4'b0110);

    // funct[0] clear selects the signed variants (mult, div)
    assign s1    = ~funct_i[0] & src1_i[DATA_W-1];
    assign s2    = ~funct_i[0] & src2_i[DATA_W-1];
    assign a_mag = s1 ? -src1_i : src1_i;
    assign b_mag = s2 ? -src2_i : src2_i;

    // wk holds multiplier / dividend, opnd holds multiplicand / divisor
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (wk_q[0] ? {1'b0, opnd_q} : '0);
        mul_acc_n = mul_sum[DATA_W:1];
        mul_wk_n  = {mul_sum[0], wk_q[DATA_W-1:1]};

        div_sh    = {acc_q, wk_q[DATA_W-1]};
        div_ge    = (div_sh >= {1'b0, opnd_q});
        div_acc_n = div_ge ? DATA_W'(div_sh - {1'b0, opnd_q}) : div_sh[DATA_W-1:0];
        div_wk_n  = {wk_q[DATA_W-2:0], div_ge};

        prod_u    = {mul_acc_n, mul_wk_n};
        prod_s    = neg_q ? -prod_u : prod_u;
        quo_s     = neg_q ? -div_wk_n : div_wk_n;
        rem_s     = rem_neg_q ? -div_acc_n : div_acc_n;
        // divide by zero: remainder already reconstructs the dividend
        if (opnd_q == '0) begin
            quo_s = '1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        wk_d      = wk_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (mdu_req) begin
                    state_d   = BUSY;
                    cnt_d     = '0;
                    acc_d     = '0;
                    wk_d      = a_mag;
                    opnd_d    = b_mag;
                    is_div_d  = funct_i[1];
                    neg_d     = s1 ^ s2;
                    rem_neg_d = s1;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = is_div_q ? div_acc_n : mul_acc_n;
                wk_d  = is_div_q ? div_wk_n : mul_wk_n;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    hi_d    = is_div_q ? rem_s : prod_s[2*DATA_W-1:DATA_W];
                    lo_d    = is_div_q ? quo_s : prod_s[DATA_W-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            wk_q      <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            wk_q      <= wk_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // gated by reset so a request held during reset does not stall
    assign stall_o = rst_i & (((state_q == IDLE) & mdu_req) | (state_q == BUSY));
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
